// File: rtl/scarv_cop_aes_issue.sv
// Issue/writeback sequencer between the instruction decoder and the AES unit.
// Optional feature: define SCARV_COP_AES_ISSUE_TIMEOUT_EN to abandon instructions the AES unit never completes.
module scarv_cop_aes_issue (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [14:0] id_subclass,
    input  logic [3:0]  id_rd,
    input  logic [31:0] id_rs1,
    input  logic [31:0] id_rs2,
    output logic        aes_ivalid,
    output logic [31:0] aes_rs1,
    output logic [31:0] aes_rs2,
    output logic [14:0] aes_subclass,
    input  logic        aes_idone,
    input  logic [3:0]  aes_cpr_rd_ben,
    input  logic [31:0] aes_cpr_rd_wdata,
    output logic        cpr_wen,
    output logic [3:0]  cpr_waddr,
    output logic [3:0]  cpr_wben,
    output logic [31:0] cpr_wdata,
    output logic        aes_busy,
    output logic        aes_err
);

    // Subclass bit positions of the six AES instructions.
    localparam int SCARV_COP_SCLASS_AESSUB_ENC    = 0;
    localparam int SCARV_COP_SCLASS_AESSUB_ENCROT = 1;
    localparam int SCARV_COP_SCLASS_AESSUB_DEC    = 2;
    localparam int SCARV_COP_SCLASS_AESSUB_DECROT = 3;
    localparam int SCARV_COP_SCLASS_AESMIX_ENC    = 4;
    localparam int SCARV_COP_SCLASS_AESMIX_DEC    = 5;

    localparam logic [14:0] AES_MASK =
        (15'd1 << SCARV_COP_SCLASS_AESSUB_ENC)    |
        (15'd1 << SCARV_COP_SCLASS_AESSUB_ENCROT) |
        (15'd1 << SCARV_COP_SCLASS_AESSUB_DEC)    |
        (15'd1 << SCARV_COP_SCLASS_AESSUB_DECROT) |
        (15'd1 << SCARV_COP_SCLASS_AESMIX_ENC)    |
        (15'd1 << SCARV_COP_SCLASS_AESMIX_DEC);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [14:0] sub_q, sub_d;
    logic [3:0]  rd_q, rd_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  ben_q, ben_d;
    logic        err_q, err_d;

    logic accept;
    logic is_aes;
    logic in_busy;
    logic in_wb;
    logic timeout;

    assign in_busy = (state_q == BUSY);
    assign in_wb   = (state_q == WB);
    assign accept  = id_valid && id_ready;
    assign is_aes  = |(id_subclass & AES_MASK);

`ifdef SCARV_COP_AES_ISSUE_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;

    // Held at zero outside BUSY, so every entry to BUSY starts a fresh count.
    always_comb begin
        cnt_d = 4'd0;
        if (in_busy) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count reaches 15 at the end of the fifteenth BUSY cycle.
    assign timeout = (cnt_q == 4'd14);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        wdata_d = wdata_q;
        ben_d   = ben_q;
        err_d   = 1'b0;

        if (accept) begin
            sub_d = id_subclass;
            rd_d  = id_rd;
            rs1_d = id_rs1;
            rs2_d = id_rs2;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_aes) begin
                        state_d = BUSY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (aes_idone) begin
                    state_d = WB;
                    wdata_d = aes_cpr_rd_wdata;
                    ben_d   = aes_cpr_rd_ben;
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            WB: begin
                // A new instruction may be accepted while the previous result retires.
                if (accept && is_aes) begin
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                    err_d   = accept;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            sub_q   <= 15'd0;
            rd_q    <= 4'd0;
            rs1_q   <= 32'd0;
            rs2_q   <= 32'd0;
            wdata_q <= 32'd0;
            ben_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            wdata_q <= wdata_d;
            ben_q   <= ben_d;
            err_q   <= err_d;
        end
    end

    // All outputs decode registered state, so reset clears them without a clock.
    assign id_ready     = !in_busy;
    assign aes_ivalid   = in_busy;
    assign aes_busy     = in_busy;
    assign aes_subclass = in_busy ? sub_q : 15'd0;
    assign aes_rs1      = in_busy ? rs1_q : 32'd0;
    assign aes_rs2      = in_busy ? rs2_q : 32'd0;

    assign cpr_wen      = in_wb;
    assign cpr_waddr    = in_wb ? rd_q    : 4'd0;
    assign cpr_wben     = in_wb ? ben_q   : 4'd0;
    assign cpr_wdata    = in_wb ? wdata_q : 32'd0;

    assign aes_err      = err_q;

endmodule

// File: doc/scarv_cop_aes_issue.md
SCARV_COP_AES_ISSUE -- requirements
Module: scarv_cop_aes_issue

Interface
REQ-001 g_clk  input  1  sole clock; all state updates on rising edge.
REQ-002 g_resetn  input  1  asynchronous active-low reset.
REQ-003 id_valid  input  1  decoded AES instruction offered.
REQ-004 id_ready  output  1  issuer accepts an instruction this cycle.
REQ-005 id_subclass  input  15  decoded subclass; AES bits use the SCARV_COP_SCLASS_AES* positions.
REQ-006 id_rd  input  4  destination CPR index.
REQ-007 id_rs1, id_rs2  input  32  source operand values.
REQ-008 aes_ivalid  output  1  instruction valid to the AES unit.
REQ-009 aes_rs1, aes_rs2  output  32  held operands to the AES unit.
REQ-010 aes_subclass  output  15  held subclass to the AES unit.
REQ-011 aes_idone  input  1  AES unit completion.
REQ-012 aes_cpr_rd_ben, aes_cpr_rd_wdata  input  4, 32  AES unit result.
REQ-013 cpr_wen  output  1  CPR write strobe.
REQ-014 cpr_waddr, cpr_wben, cpr_wdata  output  4, 4, 32  CPR write address, byte enables, data.
REQ-015 aes_busy  output  1  high in BUSY state.
REQ-016 aes_err  output  1  one-cycle error pulse.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY and WB.
REQ-018 id_ready SHALL be high in IDLE and WB, and low in BUSY.
REQ-019 Accept = id_valid && id_ready; on accept the block SHALL register subclass, rd, rs1 and rs2 and enter BUSY next cycle.
REQ-020 On an accept where none of the six AES subclass bits are set, the block SHALL NOT enter BUSY, SHALL pulse aes_err next cycle, and SHALL perform no CPR write.
REQ-021 In BUSY, aes_ivalid SHALL be high continuously, with aes_rs1, aes_rs2 and aes_subclass held stable from the registers.
REQ-022 In IDLE and WB, aes_ivalid SHALL be low and aes_subclass SHALL be zero.
REQ-023 In BUSY with aes_idone high, the block SHALL capture aes_cpr_rd_wdata and aes_cpr_rd_ben and enter WB next cycle.
REQ-024 In WB, cpr_wen SHALL be high for exactly one cycle, with cpr_waddr = registered rd, cpr_wdata = captured data and cpr_wben = captured ben.
REQ-025 From WB: on accept go to BUSY (back-to-back issue); otherwise go to IDLE.
REQ-026 aes_idone seen outside BUSY SHALL be ignored.
REQ-027 Latency with a 4-cycle AES unit: accept in cycle N, aes_ivalid in N+1..N+4, cpr_wen in N+5.
REQ-028 cpr_wen, cpr_waddr, cpr_wben and cpr_wdata SHALL be zero whenever the block is not in WB.

Reset
REQ-029 Asserting g_resetn low SHALL immediately force state IDLE and clear all registers to zero.
REQ-030 While in reset, every output SHALL be 0 except id_ready, which SHALL be 1 once reset is released.
REQ-031 Reset asserted mid-BUSY SHALL drop aes_ivalid asynchronously with no CPR write.

Configuration
REQ-032 The macro SCARV_COP_AES_ISSUE_TIMEOUT_EN, when defined, SHALL add a 4-bit cycle counter that clears on entry to BUSY and increments each BUSY cycle.
REQ-033 With SCARV_COP_AES_ISSUE_TIMEOUT_EN defined, if the counter reaches 15 without aes_idone, the block SHALL return to IDLE, pulse aes_err, and perform no CPR write.
REQ-034 With SCARV_COP_AES_ISSUE_TIMEOUT_EN undefined, the counter SHALL be absent and BUSY SHALL wait indefinitely for aes_idone.

Verification
REQ-035 Issue mix-enc with rs1=0x000013DB, rs2=0x45530000 to a connected AES unit -> cpr_wen in cycle N+5 with cpr_wdata=0xBCA14D8E and cpr_wben=0xF.
REQ-036 Issue sub-enc with rs1=rs2=0x00000000, rd=5 -> single cpr_wen, cpr_waddr=5, cpr_wdata=0x63636363.
REQ-037 Issue two instructions with id_valid held high -> second accept occurs in the WB cycle of the first, and cpr_wen pulses are exactly 5 cycles apart.
REQ-038 Accept with id_subclass=0 -> aes_err pulses one cycle later, aes_ivalid never rises, cpr_wen stays 0.
REQ-039 Drop g_resetn during the 2nd BUSY cycle -> aes_ivalid falls without waiting for a clock edge, there is no cpr_wen, and id_ready=1 after release.
REQ-040 With SCARV_COP_AES_ISSUE_TIMEOUT_EN defined and aes_idone tied low -> aes_err pulses after 15 BUSY cycles, then IDLE with id_ready=1.
